// File: rtl/spi_packet_rx_if.sv
// spi_packet_rx_if: SPI pins plus packet handshake bundle for the packet receiver
interface spi_packet_rx_if #(
    parameter int PACKET_BITS = 24
);
    logic                   cs;
    logic                   sck;
    logic                   sdi;
    logic [PACKET_BITS-1:0] packet;
    logic                   packet_valid;
    logic                   packet_ready;
    logic                   frame_err;
    logic                   overflow;
    logic                   busy;

    modport master (
        output cs, sck, sdi, packet_ready,
        input  packet, packet_valid, frame_err, overflow, busy
    );

    modport slave (
        input  cs, sck, sdi, packet_ready,
        output packet, packet_valid, frame_err, overflow, busy
    );
endinterface

// File: rtl/spi_packet_rx.sv
// spi_packet_rx: oversampling SPI slave that assembles fixed-length frames into a valid/ready packet
module spi_packet_rx #(
    parameter int PACKET_BITS = 24,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    spi_packet_rx_if.slave bus
);
    localparam int CW = $clog2(PACKET_BITS + 2);
    localparam int SW = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DISCARD} state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0]   sync_q, sync_d;
    logic [1:0]                    dly_q, dly_d;
    logic [SW-1:0]                 settle_q, settle_d;
    logic [PACKET_BITS-1:0]        shift_q, shift_d, packet_q, packet_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          done_q, done_d, err_q, err_d;
    logic                          valid_q, valid_d, ovf_q, ovf_d;
    logic                          cs_s, sck_s, sdi_s;
    logic                          cs_rise, cs_fall, sck_rise;
    logic                          start, shift_en, load, busy;

    assign {cs_s, sck_s, sdi_s} = sync_q[SYNC_STAGES-1];

    // State register; a reset that lands inside a frame parks in DISCARD
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= cs_s ? DISCARD : IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; while the cleared synchronizers refill, a high cs is a frame already in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (settle_q != '0) begin
                         if (cs_s) state_d = DISCARD;
                     end else if (cs_rise) begin
                         state_d = SHIFT;
                     end
            SHIFT:   if (cs_fall) state_d = IDLE;
            DISCARD: if (!cs_s && settle_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame start, bit capture, completion and malformed-frame detection
    always_comb begin
        start    = (state_q == IDLE) && (settle_q == '0) && cs_rise;
        shift_en = (state_q == SHIFT) && sck_rise && !cs_fall;
        done_d   = (state_q == SHIFT) && cs_fall && (cnt_q == CW'(PACKET_BITS));
        err_d    = (state_q == SHIFT) && cs_fall && (cnt_q != CW'(PACKET_BITS));
        busy     = (state_q != IDLE);
    end

    // Synchronizers, edge detectors, shifter and the packet handshake
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], {bus.cs, bus.sck, bus.sdi}};
        dly_d    = {cs_s, sck_s};
        cs_rise  = cs_s & ~dly_q[1];
        cs_fall  = ~cs_s & dly_q[1];
        sck_rise = sck_s & ~dly_q[0];
        settle_d = (settle_q != '0) ? settle_q - SW'(1) : settle_q;
        shift_d  = start ? '0 : shift_en ? {shift_q[PACKET_BITS-2:0], sdi_s} : shift_q;
        cnt_d    = start ? '0
                 : (shift_en && cnt_q != CW'(PACKET_BITS + 1)) ? cnt_q + CW'(1) : cnt_q;
        load     = done_q && (!valid_q || bus.packet_ready);
        valid_d  = load ? 1'b1 : bus.packet_ready ? 1'b0 : valid_q;
        packet_d = load ? shift_q : packet_q;
        ovf_d    = ovf_q | (done_q & valid_q & ~bus.packet_ready);
    end

    // Datapath registers; completion is registered once so the packet lands SYNC_STAGES+2 edges after cs drops
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            dly_q    <= '0;
            settle_q <= SW'(SYNC_STAGES + 1);
            shift_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            packet_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            settle_q <= settle_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            packet_q <= packet_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.packet       = packet_q;
    assign bus.packet_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.overflow     = ovf_q;
    assign bus.busy         = busy;
endmodule

// File: doc/spi_packet_rx.md
SPI_PACKET_RX -- requirements
Module: spi_packet_rx

Interface
REQ-001 Parameter PACKET_BITS, default 24, number of bits per SPI frame.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of input synchronizers (min 2).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  asynchronous chip select; high = frame active.
REQ-006 sck  input  1  asynchronous SPI clock; sdi sampled on its rising edge.
REQ-007 sdi  input  1  asynchronous serial data, MSB first.
REQ-008 packet  output  PACKET_BITS  last accepted frame, stable while packet_valid high.
REQ-009 packet_valid  output  1  high while packet holds an unconsumed frame.
REQ-010 packet_ready  input  1  downstream (motor-drive command decoder) consumes packet on a clk edge where valid and ready are both high.
REQ-011 frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-012 overflow  output  1  sticky flag: a complete frame was dropped.
REQ-013 busy  output  1  high while state is SHIFT or DISCARD.

Function
REQ-014 cs, sck and sdi SHALL each pass through a SYNC_STAGES-deep flop chain; all logic uses the synchronized versions only.
REQ-015 Edge detection SHALL compare the synchronized signal with a one-cycle-delayed copy; one detected edge per transition.
REQ-016 Legal sck high and low times SHALL each be >= 2 clk periods; narrower pulses are out of spec and need not be captured.
REQ-017 FSM states: IDLE, SHIFT, DISCARD.
REQ-018 IDLE: on synchronized cs rising edge -> SHIFT, shift register and bit counter cleared.
REQ-019 SHIFT: on each synchronized sck rising edge, shift register shifts left with sdi into bit 0; bit counter increments, saturating at PACKET_BITS+1.
REQ-020 SHIFT: on synchronized cs falling edge with count == PACKET_BITS -> frame complete, return to IDLE.
REQ-021 SHIFT: on cs falling edge with count != PACKET_BITS (short or long) -> frame_err high for exactly one cycle, data discarded, return to IDLE.
REQ-022 sck edges while in IDLE or DISCARD SHALL be ignored.
REQ-023 Frame complete with packet_valid low, or with packet_valid and packet_ready both high that cycle: packet loaded, packet_valid high on the next edge, overflow unchanged.
REQ-024 Frame complete with packet_valid high and packet_ready low: new frame dropped, packet unchanged, overflow set to 1.
REQ-025 packet_valid SHALL clear on the edge where packet_ready is high, unless REQ-023 reloads the same cycle.
REQ-026 Latency: packet_valid rises on the (SYNC_STAGES+2)th rising clk edge after the first edge sampling cs low at the pin.
REQ-027 packet SHALL not change while packet_valid is high except on a consuming edge.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 On reset: state DISCARD if synchronized cs is high, else IDLE; packet = 0, packet_valid = 0, frame_err = 0, overflow = 0, shift register, counter and synchronizer flops = 0.
REQ-030 Because synchronizers clear to 0, a frame in progress at reset SHALL be treated as ongoing: state DISCARD is entered on the first synchronized cs high after reset and held until synchronized cs falls, then IDLE, with no frame_err.
REQ-031 Reset asserted mid-frame SHALL discard that frame entirely; no packet_valid or frame_err from it.

Verification
REQ-032 Frame 0x0114FF, sck period 4 clk, ready low -> packet = 0x0114FF, packet_valid = 1 per REQ-026 latency, frame_err = 0, overflow = 0.
REQ-033 With 0x0114FF held and ready low, send 0xABCDEF -> overflow = 1, packet stays 0x0114FF; then ready high one cycle -> packet_valid = 0, overflow stays 1.
REQ-034 20-bit frame, then 25-bit frame -> one frame_err pulse each, packet_valid never rises.
REQ-035 Reset pulse after 10 bits of a frame, remaining 14 bits sent, cs drops -> no valid, no frame_err; next frame 0x123456 -> packet = 0x123456.
REQ-036 Frame 0x00AA55 completes on the same edge packet_ready consumes prior 0x0114FF -> packet = 0x00AA55, packet_valid stays 1, overflow = 0.
REQ-037 sck edges toggled with cs low, then frame 0xFFFFFF -> ignored edges cause no error; packet = 0xFFFFFF.
